// File: rtl/uart_receiver.sv
// UART 8N1 receiver: oversampled start/data/stop detection, RBR holding register with ready/overrun/framing flags.
// Latency: ~2 + OVERSAMPLE/2 + (DATA_BITS+1)*OVERSAMPLE bclk from start-bit falling edge to rx_ready (154 at defaults).
// Backpressure: none on the line; a frame completing while rx_ready=1 (and no rd_en) is dropped and sets overrun_err.
//
// Ports:
//   bclk        oversampling clock (OVERSAMPLE x baud), rising edge
//   rst         asynchronous active-low reset
//   rx_data     serial input, asynchronous to bclk, idles high
//   rd_en       one-cycle read acknowledge from the consumer
//   RBR         received byte, held until the next accepted frame
//   rx_ready    RBR holds an unread byte
//   rx_status   frame in progress (START/DATA/STOP)
//   frame_err   stop bit of the last loaded byte was 0
//   overrun_err sticky: a completed frame was dropped because RBR was unread
module uart_receiver #(
    parameter int OVERSAMPLE = 16,   // even, >= 4
    parameter int DATA_BITS  = 8     // >= 2
) (
    input  logic                 bclk,
    input  logic                 rst,
    input  logic                 rx_data,
    input  logic                 rd_en,
    output logic [DATA_BITS-1:0] RBR,
    output logic                 rx_ready,
    output logic                 rx_status,
    output logic                 frame_err,
    output logic                 overrun_err
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);

    localparam logic [TW-1:0] TICK_MID = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_END = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t                 state_q, state_d;
    logic                   sync1_q;
    logic                   rx_s_q;
    logic [TW-1:0]          tick_q, tick_d;
    logic [BW-1:0]          bit_q, bit_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [DATA_BITS-1:0]   rbr_q, rbr_d;
    logic                   ready_q, ready_d;
    logic                   ferr_q, ferr_d;
    logic                   ovr_q, ovr_d;
    logic                   complete;

    // Two-flop synchronizer; reset to the idle (high) line level so that
    // leaving reset never looks like a start bit.
    always_ff @(posedge bclk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
        end else begin
            sync1_q <= rx_data;
            rx_s_q  <= sync1_q;
        end
    end

    always_ff @(posedge bclk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            rbr_q   <= '0;
            ready_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            rbr_q   <= rbr_d;
            ready_q <= ready_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        tick_d   = tick_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        rbr_d    = rbr_q;
        ready_d  = ready_q;
        ferr_d   = ferr_q;
        ovr_d    = ovr_q;
        complete = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (!rx_s_q) begin
                    tick_d  = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                // Re-check the line at the start-bit centre to reject glitches.
                if (tick_q == TICK_MID) begin
                    if (!rx_s_q) begin
                        tick_d  = '0;
                        bit_d   = '0;
                        state_d = S_DATA;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    tick_d = tick_q + TW'(1);
                end
            end
            S_DATA: begin
                // Counter is phase-aligned to bit centres by the START exit,
                // so the wrap point is the middle of each data bit.
                if (tick_q == TICK_END) begin
                    tick_d  = '0;
                    shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
                    bit_d   = bit_q + BW'(1);
                    if (bit_q == BIT_LAST) begin
                        state_d = S_STOP;
                    end
                end else begin
                    tick_d = tick_q + TW'(1);
                end
            end
            S_STOP: begin
                if (tick_q == TICK_END) begin
                    tick_d   = '0;
                    complete = 1'b1;
                    state_d  = rx_s_q ? S_IDLE : S_BREAK;
                end else begin
                    tick_d = tick_q + TW'(1);
                end
            end
            S_BREAK: begin
                // A held-low line must return high before a new frame can start.
                if (rx_s_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A same-cycle rd_en frees RBR for the completing frame.
        if (complete) begin
            if (!ready_q || rd_en) begin
                rbr_d   = shift_q;
                ferr_d  = ~rx_s_q;
                ready_d = 1'b1;
                if (rd_en) begin
                    ovr_d = 1'b0;
                end
            end else begin
                ovr_d = 1'b1;
            end
        end else if (rd_en && ready_q) begin
            ready_d = 1'b0;
            ovr_d   = 1'b0;
        end
    end

    assign RBR         = rbr_q;
    assign rx_ready    = ready_q;
    assign frame_err   = ferr_q;
    assign overrun_err = ovr_q;
    assign rx_status   = (state_q == S_START) || (state_q == S_DATA) || (state_q == S_STOP);

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at OVERSAMPLE=16, DATA_BITS=8.
// Inputs are driven on the falling edge of bclk; outputs are sampled on the falling edge.
module tb_uart_receiver;

    logic       bclk;
    logic       rst;
    logic       rx_data;
    logic       rd_en;
    logic [7:0] RBR;
    logic       rx_ready;
    logic       rx_status;
    logic       frame_err;
    logic       overrun_err;

    int n_checks = 0;
    int n_fails  = 0;

    uart_receiver #(
        .OVERSAMPLE (16),
        .DATA_BITS  (8)
    ) dut (
        .bclk        (bclk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rd_en       (rd_en),
        .RBR         (RBR),
        .rx_ready    (rx_ready),
        .rx_status   (rx_status),
        .frame_err   (frame_err),
        .overrun_err (overrun_err)
    );

    initial bclk = 1'b0;
    always #5 bclk = ~bclk;

    // Hard stop in case anything ever stalls.
    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Sends one full 10-bit frame, 16 bclk per bit, starting at a falling edge.
    // k counts rising edges since the start bit was driven. rd_en is high
    // for the cycle ending at rising edge rd_at (0 = never).
    task automatic send_frame(input logic [7:0] data, input logic stop, input int rd_at,
                              output int rdy_at, output logic st_mid, output logic st_end);
        logic [9:0] fr;
        fr     = {stop, data, 1'b0};
        rdy_at = -1;
        st_mid = 1'b0;
        for (int k = 1; k <= 160; k++) begin
            rx_data = fr[(k - 1) / 16];
            rd_en   = (k == rd_at);
            @(posedge bclk);
            @(negedge bclk);
            if (rdy_at < 0 && rx_ready) rdy_at = k;
            if (k == 80) st_mid = rx_status;
        end
        rd_en  = 1'b0;
        st_end = rx_status;
    endtask

    task automatic pulse_rd();
        rd_en = 1'b1;
        @(negedge bclk);
        rd_en = 1'b0;
    endtask

    task automatic check_reset_outputs(input string phase);
        check({phase, "_rbr"},       32'(RBR),         32'h0);
        check({phase, "_rx_ready"},  32'(rx_ready),    32'd0);
        check({phase, "_rx_status"}, 32'(rx_status),   32'd0);
        check({phase, "_frame_err"}, 32'(frame_err),   32'd0);
        check({phase, "_overrun"},   32'(overrun_err), 32'd0);
    endtask

    initial begin
        int         rdy_at;
        logic       st_mid;
        logic       st_end;
        logic       seen;
        logic [9:0] fr;

        rst     = 1'b0;
        rx_data = 1'b1;
        rd_en   = 1'b0;
        repeat (3) @(negedge bclk);
        check_reset_outputs("reset");
        rst = 1'b1;
        repeat (5) @(negedge bclk);

        // Single clean frame 0xA5: data, flags, latency and status window.
        send_frame(8'hA5, 1'b1, 0, rdy_at, st_mid, st_end);
        check("a5_rbr",       32'(RBR),       32'hA5);
        check("a5_rx_ready",  32'(rx_ready),  32'd1);
        check("a5_frame_err", 32'(frame_err), 32'd0);
        check("a5_status_mid", 32'(st_mid),   32'd1);
        check("a5_status_end", 32'(st_end),   32'd0);
        n_checks++;
        assert (rdy_at >= 154 && rdy_at <= 156) else begin
            n_fails++;
            $error("FAIL a5_latency: observed %0d cycles expected 154..156", rdy_at);
        end
        pulse_rd();
        check("a5_rd_clears_ready", 32'(rx_ready), 32'd0);

        // 4-cycle glitch: START entered briefly, rejected at the centre check.
        seen    = 1'b0;
        rx_data = 1'b0;
        repeat (4) begin
            @(negedge bclk);
            seen |= rx_status;
        end
        rx_data = 1'b1;
        repeat (20) begin
            @(negedge bclk);
            seen |= rx_status;
        end
        check("glitch_status_pulsed", 32'(seen),      32'd1);
        check("glitch_status_idle",   32'(rx_status), 32'd0);
        check("glitch_rx_ready",      32'(rx_ready),  32'd0);
        check("glitch_rbr",           32'(RBR),       32'hA5);

        // Frame 0x3C with a 0 stop bit, then line held low: BREAK, no retrigger.
        send_frame(8'h3C, 1'b0, 0, rdy_at, st_mid, st_end);
        seen = st_end;
        repeat (40) begin
            @(negedge bclk);
            seen |= rx_status;
        end
        check("brk_rbr",         32'(RBR),       32'h3C);
        check("brk_frame_err",   32'(frame_err), 32'd1);
        check("brk_rx_ready",    32'(rx_ready),  32'd1);
        check("brk_no_retrigger", 32'(seen),     32'd0);
        rx_data = 1'b1;
        repeat (30) @(negedge bclk);
        check("brk_release_status",  32'(rx_status),   32'd0);
        check("brk_release_overrun", 32'(overrun_err), 32'd0);
        check("brk_release_rbr",     32'(RBR),         32'h3C);
        pulse_rd();

        // Back-to-back 0x11, 0x22 with no read: second frame is dropped.
        send_frame(8'h11, 1'b1, 0, rdy_at, st_mid, st_end);
        send_frame(8'h22, 1'b1, 0, rdy_at, st_mid, st_end);
        check("ovr_rbr",       32'(RBR),         32'h11);
        check("ovr_rx_ready",  32'(rx_ready),    32'd1);
        check("ovr_overrun",   32'(overrun_err), 32'd1);
        check("ovr_frame_err", 32'(frame_err),   32'd0);
        pulse_rd();
        check("ovr_rd_ready",   32'(rx_ready),    32'd0);
        check("ovr_rd_overrun", 32'(overrun_err), 32'd0);

        // rd_en exactly on the completion cycle: new byte loads, overrun cleared.
        send_frame(8'h77, 1'b1, 0, rdy_at, st_mid, st_end);
        send_frame(8'h66, 1'b1, 0, rdy_at, st_mid, st_end);
        check("rdc_pre_overrun", 32'(overrun_err), 32'd1);
        check("rdc_pre_rbr",     32'(RBR),         32'h77);
        send_frame(8'h55, 1'b1, 155, rdy_at, st_mid, st_end);
        check("rdc_rbr",      32'(RBR),         32'h55);
        check("rdc_rx_ready", 32'(rx_ready),    32'd1);
        check("rdc_overrun",  32'(overrun_err), 32'd0);

        // Reset in the middle of 0xF0's data bits, then a clean 0x0F.
        fr = {1'b1, 8'hF0, 1'b0};
        for (int k = 1; k <= 60; k++) begin
            rx_data = fr[(k - 1) / 16];
            @(negedge bclk);
        end
        check("midrst_status_before", 32'(rx_status), 32'd1);
        rst     = 1'b0;
        rx_data = 1'b1;
        #1;
        check_reset_outputs("midrst_async");
        repeat (5) @(negedge bclk);
        check_reset_outputs("midrst_held");
        rst = 1'b1;
        repeat (5) @(negedge bclk);
        check("midrst_post_ready",  32'(rx_ready),  32'd0);
        check("midrst_post_status", 32'(rx_status), 32'd0);
        send_frame(8'h0F, 1'b1, 0, rdy_at, st_mid, st_end);
        check("post_rbr",       32'(RBR),         32'h0F);
        check("post_rx_ready",  32'(rx_ready),    32'd1);
        check("post_frame_err", 32'(frame_err),   32'd0);
        check("post_overrun",   32'(overrun_err), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- Serial-to-parallel receive half of the UART; the counterpart of the existing transmitter.
- Accepts an 8N1 frame on rx_data: one low start bit, 8 data bits LSB first, one high stop bit.
- bclk is an oversampling clock running at OVERSAMPLE x baud. Each bit is sampled at its centre.
- The received byte is presented in RBR with a ready flag, plus framing and overrun flags.

Parameters:
OVERSAMPLE, 16, bclk cycles per bit period; even, >= 4.
DATA_BITS, 8, data bits per frame; RBR width.

Ports:
bclk  input  1  sampling clock; all logic on rising edge.
rst  input  1  asynchronous, active-low reset.
rx_data  input  1  serial line, asynchronous to bclk, idles high.
rd_en  input  1  one-cycle pulse from the consumer; acknowledges RBR and clears rx_ready and overrun_err.
RBR  output  DATA_BITS  received byte; holds its value until the next accepted frame.
rx_ready  output  1  RBR holds an unread byte.
rx_status  output  1  a frame is being received (START, DATA or STOP).
frame_err  output  1  the stop bit of the last byte loaded into RBR was 0.
overrun_err  output  1  sticky; a frame completed while rx_ready=1 and was dropped.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - Both synchronizer flops are forced to 1.
  - The tick counter, bit counter and shift register clear to 0.
  - RBR=0, rx_ready=0, rx_status=0, frame_err=0, overrun_err=0.
  - A reset in the middle of a frame abandons the frame; nothing is loaded.
- Input synchronizer: two flops. rx_s is the second flop; all decisions use rx_s only.
- State machine has five states: IDLE, START, DATA, STOP, BREAK.
  - IDLE: when rx_s=0, clear the tick counter and go to START.
  - START: count ticks. At tick OVERSAMPLE/2-1 (start-bit centre):
    - rx_s=0: clear the tick counter and bit counter, go to DATA.
    - rx_s=1: false start (glitch), go to IDLE.
  - DATA: the tick counter runs 0..OVERSAMPLE-1 and wraps. At OVERSAMPLE-1:
    - Shift rx_s into the MSB of the shift register and shift right, so the first bit received ends in bit 0.
    - Increment the bit counter.
    - After the DATA_BITS-th sample, go to STOP.
  - STOP: at tick OVERSAMPLE-1, sample the stop bit and run the completion event (below).
    - rx_s=1: go to IDLE.
    - rx_s=0: go to BREAK.
  - BREAK: wait until rx_s=1, then go to IDLE. A held-low line never retriggers a frame.
- Completion event (registered, takes effect the cycle after the stop sample):
  - rx_ready=0, or rd_en=1 in the same cycle:
    - RBR <= shift register.
    - frame_err <= ~stop sample.
    - rx_ready <= 1.
  - rx_ready=1 and rd_en=0:
    - RBR and frame_err are unchanged and the new byte is dropped.
    - overrun_err <= 1.
- rd_en:
  - With rx_ready=1 and no completion in the same cycle: clears rx_ready and overrun_err on the next edge.
  - With rx_ready=0: no effect.
  - rd_en together with a completion: the new byte loads, rx_ready stays 1, overrun_err is cleared.
- rx_status is combinational from state: 1 in START, DATA and STOP; 0 in IDLE and BREAK.
- Latency from the rx_data falling edge to rx_ready=1 is about 2 + OVERSAMPLE/2 + (DATA_BITS+1)*OVERSAMPLE bclk cycles: 154 for the defaults, +/-1 for synchronizer alignment.
- A new start bit is detected as soon as the machine is back in IDLE. Back-to-back frames with no idle gap must be received.

Test Plan:
- After reset, drive frame 0xA5 (16 cycles per bit) -> RBR=0xA5, rx_ready=1 about 154 cycles after the start edge, frame_err=0; rx_status high only during the frame.
- 4-cycle low glitch on an idle line -> rx_status pulses then returns to 0; rx_ready stays 0 and RBR is unchanged.
- Frame 0x3C with stop bit 0, line held low 40 more cycles -> RBR=0x3C, frame_err=1; FSM stays in BREAK; no spurious frame until the line returns high.
- Frames 0x11 then 0x22 back-to-back, no rd_en -> RBR=0x11, overrun_err=1; one rd_en pulse -> rx_ready=0, overrun_err=0.
- rd_en asserted on the exact completion cycle of the second frame 0x55 -> RBR=0x55, rx_ready=1, overrun_err=0.
- rst=0 in the middle of the DATA bits of 0xF0, then released and frame 0x0F sent -> outputs at reset values during reset; only RBR=0x0F is received, with no error flags.
